// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: decode-side stall/redirect requests, instruction-memory port, IF/ID register and return-stack status.
// master = decode / memory side, slave = fetch stage.
interface fetch_stage_if #(
    parameter int ADDRESS_LEN     = 12,
    parameter int INSTRUCTION_LEN = 19,
    parameter int STACK_DEPTH     = 8
);
    localparam int COUNT_LEN = $clog2(STACK_DEPTH + 1);

    logic                       stall;
    logic                       redirect;
    logic [1:0]                 redirect_kind;
    logic [ADDRESS_LEN-1:0]     redirect_target;
    logic [7:0]                 redirect_offset;
    logic [ADDRESS_LEN-1:0]     redirect_base;
    logic [ADDRESS_LEN-1:0]     im_addr;
    logic [INSTRUCTION_LEN-1:0] im_data;
    logic [INSTRUCTION_LEN-1:0] pr1_instruction;
    logic [ADDRESS_LEN-1:0]     pr1_pc_plus1;
    logic                       pr1_valid;
    logic [COUNT_LEN-1:0]       stack_count;
    logic                       stack_overflow;
    logic                       stack_underflow;

    modport master (
        output stall, redirect, redirect_kind, redirect_target, redirect_offset, redirect_base, im_data,
        input  im_addr, pr1_instruction, pr1_pc_plus1, pr1_valid, stack_count, stack_overflow, stack_underflow
    );

    modport slave (
        input  stall, redirect, redirect_kind, redirect_target, redirect_offset, redirect_base, im_data,
        output im_addr, pr1_instruction, pr1_pc_plus1, pr1_valid, stack_count, stack_overflow, stack_underflow
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch with PC, next-PC select, return-address stack and IF/ID register.
// Latency: im_addr is combinational from PC; fetched word lands in IF/ID one cycle later.
// Backpressure: stall holds PC, IF/ID and stack; redirect beats stall and inserts one bubble.
module fetch_stage #(
    parameter int                       ADDRESS_LEN     = 12,
    parameter int                       INSTRUCTION_LEN = 19,
    parameter int                       STACK_DEPTH     = 8,
    parameter logic [ADDRESS_LEN-1:0]   RESET_PC        = '0
) (
    input  logic        clk,
    input  logic        rst,
    fetch_stage_if.slave bus
);
    localparam int COUNT_LEN = $clog2(STACK_DEPTH + 1);
    localparam int PTR_LEN   = $clog2(STACK_DEPTH);

    typedef enum logic [1:0] {
        KIND_JUMP   = 2'b00,
        KIND_BRANCH = 2'b01,
        KIND_CALL   = 2'b10,
        KIND_RETURN = 2'b11
    } kind_t;

    logic [ADDRESS_LEN-1:0]     pc;
    logic [ADDRESS_LEN-1:0]     pc_plus1;
    logic [ADDRESS_LEN-1:0]     target;
    logic [INSTRUCTION_LEN-1:0] pr1_instruction;
    logic [ADDRESS_LEN-1:0]     pr1_pc_plus1;
    logic                       pr1_valid;
    logic [COUNT_LEN-1:0]       count;
    logic                       overflow;
    logic                       underflow;

    logic [ADDRESS_LEN-1:0]     ras [STACK_DEPTH];
    logic [ADDRESS_LEN-1:0]     ras_top;
    logic [PTR_LEN-1:0]         top_idx;
    logic [PTR_LEN-1:0]         push_idx;
    logic                       stack_full;
    logic                       stack_empty;
    logic                       push;
    logic                       pop;
    logic                       push_blocked;
    logic                       pop_blocked;

    assign pc_plus1    = pc + ADDRESS_LEN'(1);
    assign stack_full  = (count == COUNT_LEN'(STACK_DEPTH));
    assign stack_empty = (count == '0);
    // Index wraps harmlessly when full/empty; those cases never read or write the array.
    assign top_idx     = PTR_LEN'(count - COUNT_LEN'(1));
    assign push_idx    = PTR_LEN'(count);
    assign ras_top     = ras[top_idx];

    always_comb begin
        target       = bus.redirect_target;
        push         = 1'b0;
        pop          = 1'b0;
        push_blocked = 1'b0;
        pop_blocked  = 1'b0;
        case (kind_t'(bus.redirect_kind))
            KIND_JUMP:   target = bus.redirect_target;
            KIND_BRANCH: target = bus.redirect_base + ADDRESS_LEN'($signed(bus.redirect_offset));
            KIND_CALL: begin
                target       = bus.redirect_target;
                push         = bus.redirect && !stack_full;
                push_blocked = bus.redirect && stack_full;
            end
            KIND_RETURN: begin
                target      = stack_empty ? bus.redirect_base : ras_top;
                pop         = bus.redirect && !stack_empty;
                pop_blocked = bus.redirect && stack_empty;
            end
            default: target = bus.redirect_target;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc              <= RESET_PC;
            pr1_instruction <= '0;
            pr1_pc_plus1    <= '0;
            pr1_valid       <= 1'b0;
            count           <= '0;
            overflow        <= 1'b0;
            underflow       <= 1'b0;
        end else if (bus.redirect) begin
            pc              <= target;
            pr1_instruction <= '0;
            pr1_pc_plus1    <= '0;
            pr1_valid       <= 1'b0;
            if (push)         count     <= count + COUNT_LEN'(1);
            if (pop)          count     <= count - COUNT_LEN'(1);
            if (push_blocked) overflow  <= 1'b1;
            if (pop_blocked)  underflow <= 1'b1;
        end else if (!bus.stall) begin
            pc              <= pc_plus1;
            pr1_instruction <= bus.im_data;
            pr1_pc_plus1    <= pc_plus1;
            pr1_valid       <= 1'b1;
        end
    end

    // Stack contents survive reset; only the count is cleared.
    always_ff @(posedge clk) begin
        if (!rst && push) ras[push_idx] <= bus.redirect_base;
    end

    assign bus.im_addr         = pc;
    assign bus.pr1_instruction = pr1_instruction;
    assign bus.pr1_pc_plus1    = pr1_pc_plus1;
    assign bus.pr1_valid       = pr1_valid;
    assign bus.stack_count     = count;
    assign bus.stack_overflow  = overflow;
    assign bus.stack_underflow = underflow;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: queue-based reference model checked every cycle plus literal checkpoints.
module tb_fetch_stage;
    localparam int AL = 12;
    localparam int IL = 19;
    localparam int SD = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_stage_if #(.ADDRESS_LEN(AL), .INSTRUCTION_LEN(IL), .STACK_DEPTH(SD)) bus ();

    fetch_stage #(.ADDRESS_LEN(AL), .INSTRUCTION_LEN(IL), .STACK_DEPTH(SD), .RESET_PC(12'h000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    function automatic logic [IL-1:0] tag(input logic [AL-1:0] a);
        return {7'h55, a};
    endfunction

    assign bus.im_data = tag(bus.im_addr);

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    logic [AL-1:0] m_pc;
    logic [IL-1:0] m_instr;
    logic [AL-1:0] m_pcp1;
    logic          m_valid;
    logic [AL-1:0] m_stack[$];
    logic          m_ovf;
    logic          m_unf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: next state from the architectural rules, applied at each rising edge.
    task automatic model_step();
        logic [AL-1:0] tgt;
        if (rst) begin
            m_pc = '0; m_instr = '0; m_pcp1 = '0; m_valid = 1'b0;
            m_stack.delete(); m_ovf = 1'b0; m_unf = 1'b0;
        end else if (bus.redirect) begin
            tgt = bus.redirect_target;
            case (bus.redirect_kind)
                2'd1: tgt = AL'(int'(bus.redirect_base) + int'($signed(bus.redirect_offset)));
                2'd2: if (m_stack.size() < SD) m_stack.push_back(bus.redirect_base); else m_ovf = 1'b1;
                2'd3: if (m_stack.size() > 0) tgt = m_stack.pop_back();
                      else begin m_unf = 1'b1; tgt = bus.redirect_base; end
                default: ;
            endcase
            m_pc = tgt; m_instr = '0; m_pcp1 = '0; m_valid = 1'b0;
        end else if (!bus.stall) begin
            m_instr = tag(m_pc); m_pcp1 = m_pc + AL'(1); m_valid = 1'b1; m_pc = m_pc + AL'(1);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(input logic st, input logic rd, input logic [1:0] kind,
                         input logic [AL-1:0] tgt, input logic [7:0] off, input logic [AL-1:0] base);
        bus.stall = st; bus.redirect = rd; bus.redirect_kind = kind;
        bus.redirect_target = tgt; bus.redirect_offset = off; bus.redirect_base = base;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("im_addr",         32'(bus.im_addr),         32'(m_pc));
            check("pr1_instruction", 32'(bus.pr1_instruction), 32'(m_instr));
            check("pr1_pc_plus1",    32'(bus.pr1_pc_plus1),    32'(m_pcp1));
            check("pr1_valid",       32'(bus.pr1_valid),       32'(m_valid));
            check("stack_count",     32'(bus.stack_count),     32'(m_stack.size()));
            check("stack_overflow",  32'(bus.stack_overflow),  32'(m_ovf));
            check("stack_underflow", 32'(bus.stack_underflow), 32'(m_unf));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(1'b0, 1'b0, 2'd0, 12'h000, 8'h00, 12'h000);
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        check("reset im_addr", 32'(bus.im_addr), 32'h000);
        check("reset valid",   32'(bus.pr1_valid), 32'h0);
        check("reset instr",   32'(bus.pr1_instruction), 32'h0);
        check("reset count",   32'(bus.stack_count), 32'h0);

        for (int i = 0; i < 4; i++) begin
            tick();
            check("seq im_addr", 32'(bus.im_addr), 32'(i + 1));
            check("seq pc_plus1", 32'(bus.pr1_pc_plus1), 32'(i + 1));
        end
        check("seq instr late", 32'(bus.pr1_instruction), 32'h55003);
        tick();

        drive(1'b1, 1'b0, 2'd0, 12'h000, 8'h00, 12'h000);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall im_addr", 32'(bus.im_addr), 32'h005);
            check("stall instr", 32'(bus.pr1_instruction), 32'h55004);
        end
        drive(1'b0, 1'b0, 2'd0, 12'h000, 8'h00, 12'h000);
        tick();
        check("resume im_addr", 32'(bus.im_addr), 32'h006);
        check("resume instr", 32'(bus.pr1_instruction), 32'h55005);

        drive(1'b0, 1'b1, 2'd1, 12'h000, 8'hFC, 12'h002);
        tick();
        check("branch target", 32'(bus.im_addr), 32'hFFE);
        check("branch bubble", 32'(bus.pr1_valid), 32'h0);
        drive(1'b0, 1'b0, 2'd0, 12'h000, 8'h00, 12'h000);
        tick();
        check("wrap im_addr fff", 32'(bus.im_addr), 32'hFFF);
        tick();
        check("wrap im_addr 000", 32'(bus.im_addr), 32'h000);
        check("wrap pc_plus1", 32'(bus.pr1_pc_plus1), 32'h000);
        check("wrap instr", 32'(bus.pr1_instruction), 32'h55FFF);

        drive(1'b0, 1'b1, 2'd2, 12'h100, 8'h00, 12'h010);
        tick();
        check("call target", 32'(bus.im_addr), 32'h100);
        check("call count", 32'(bus.stack_count), 32'h1);
        drive(1'b0, 1'b0, 2'd0, 12'h000, 8'h00, 12'h000);
        tick();
        drive(1'b0, 1'b1, 2'd3, 12'h000, 8'h00, 12'h102);
        tick();
        check("return target", 32'(bus.im_addr), 32'h010);
        check("return count", 32'(bus.stack_count), 32'h0);
        check("return bubble", 32'(bus.pr1_valid), 32'h0);

        for (int i = 0; i <= SD; i++) begin
            drive(1'b0, 1'b1, 2'd2, AL'(12'h200 + i), 8'h00, AL'(12'h020 + i));
            tick();
        end
        check("ovf count", 32'(bus.stack_count), 32'h8);
        check("ovf flag", 32'(bus.stack_overflow), 32'h1);
        check("ovf jump taken", 32'(bus.im_addr), 32'h208);
        for (int i = 0; i < SD; i++) begin
            drive(1'b0, 1'b1, 2'd3, 12'h000, 8'h00, 12'h300);
            tick();
            if (i == 0) check("first pop", 32'(bus.im_addr), 32'h027);
        end
        check("last pop", 32'(bus.im_addr), 32'h020);
        drive(1'b0, 1'b1, 2'd3, 12'h000, 8'h00, 12'h3AB);
        tick();
        check("unf fallthrough", 32'(bus.im_addr), 32'h3AB);
        check("unf flag", 32'(bus.stack_underflow), 32'h1);
        check("ovf sticky", 32'(bus.stack_overflow), 32'h1);

        drive(1'b0, 1'b0, 2'd0, 12'h000, 8'h00, 12'h000);
        tick();
        drive(1'b1, 1'b1, 2'd0, 12'h0AA, 8'h00, 12'h000);
        tick();
        check("stall+redirect pc", 32'(bus.im_addr), 32'h0AA);
        check("stall+redirect bubble", 32'(bus.pr1_valid), 32'h0);
        drive(1'b0, 1'b1, 2'd2, 12'h0C0, 8'h00, 12'h050);
        tick();
        drive(1'b1, 1'b0, 2'd0, 12'h000, 8'h00, 12'h000);
        tick();
        tick();
        check("pre-reset count", 32'(bus.stack_count), 32'h1);
        check("pre-reset pc", 32'(bus.im_addr), 32'h0C0);
        drive(1'b1, 1'b1, 2'd2, 12'h0DD, 8'h00, 12'h060);
        rst = 1'b1;
        tick();
        check("mid reset pc", 32'(bus.im_addr), 32'h000);
        check("mid reset valid", 32'(bus.pr1_valid), 32'h0);
        check("mid reset count", 32'(bus.stack_count), 32'h0);
        check("mid reset flags", 32'({bus.stack_overflow, bus.stack_underflow}), 32'h0);
        rst = 1'b0;
        drive(1'b0, 1'b0, 2'd0, 12'h000, 8'h00, 12'h000);
        tick();
        check("post reset fetch", 32'(bus.im_addr), 32'h001);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
